fp16_to_int32: RTL and testbench



---
 rtl/fp_conv_pkg.sv | 32 +++
 rtl/fp16_rne_shifter.sv | 24 ++
 rtl/fp16_to_int32.sv | 169 ++++++++++++++++
 tb/tb_fp16_to_int32.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fp_conv_pkg.sv
// Shared definitions for the fp16 <-> int32 conversion unit: field widths,
// operand classes and int32 saturation codes.
package fp_conv_pkg;

    localparam int FP16_EXP_W = 5;
    localparam int FP16_MAN_W = 10;
    localparam int FP16_SIG_W = FP16_MAN_W + 1;
    localparam int FP16_BIAS  = 15;

    localparam logic [31:0] INT32_POS_SAT = 32'h7FFF_FFFF;
    localparam logic [31:0] INT32_NEG_SAT = 32'h8000_0000;

    typedef enum logic [1:0] {
        NORM,
        ZERO_SUB,
        INF,
        NAN
    } fp_class_e;

    function automatic fp_class_e fp16_classify(input logic [FP16_EXP_W-1:0] exp_f,
                                                input logic [FP16_MAN_W-1:0] man_f);
        fp_class_e cls;
        if (exp_f == '1)
            cls = (man_f == '0) ? INF : NAN;
        else if (exp_f == '0)
            cls = ZERO_SUB;
        else
            cls = NORM;
        return cls;
    endfunction

endpackage

// File: rtl/fp16_rne_shifter.sv
// Right-shifts an 11-bit significand by 1..24 places and derives the
// round-to-nearest-even guard, sticky and increment bits.
module fp16_rne_shifter
    import fp_conv_pkg::*;
(
    input  logic [FP16_SIG_W-1:0] sig_i,
    input  logic [4:0]            shamt_i,
    output logic [FP16_SIG_W-1:0] mag_o,
    output logic                  guard_o,
    output logic                  sticky_o,
    output logic                  inc_o
);

    // 24 fraction bits below the significand catch every bit shifted out,
    // so shifts of 12 or more naturally give mag=0, guard=0, sticky=1.
    logic [FP16_SIG_W+23:0] wide;

    assign wide     = {sig_i, 24'b0} >> shamt_i;
    assign mag_o    = wide[FP16_SIG_W+23:24];
    assign guard_o  = wide[23];
    assign sticky_o = |wide[22:0];
    assign inc_o    = guard_o & (sticky_o | mag_o[0]);

endmodule

// File: rtl/fp16_to_int32.sv
// Three-stage fp16 -> int32 converter (round-to-nearest-even) with a
// registered output. Define FP16TOINT32_FLAGS_EN to add the flags_o port.
module fp16_to_int32
    import fp_conv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_i,
    input  logic        input_valid,
    output logic        output_update,
`ifdef FP16TOINT32_FLAGS_EN
    output logic [1:0]  flags_o,
`endif
    output logic [31:0] data_o
);

    logic                  s1_valid_q, s2_valid_q, s3_valid_q, out_valid_q;

    logic                  s1_sign_q;
    logic [FP16_SIG_W-1:0] s1_sig_q;
    fp_class_e             s1_cls_q;
    logic signed [5:0]     s1_exp_q;
    logic signed [5:0]     s1_exp_d;

    logic                  s2_sign_q, s2_inc_q, s2_inc_d;
    fp_class_e             s2_cls_q;
    logic [16:0]           s2_mag_q, s2_mag_d;

    logic [31:0]           s3_data_q, s3_data_d, mag_rounded;
    logic [31:0]           data_q;

    logic [2:0]            lsh;
    logic [4:0]            rsh;
    logic [FP16_SIG_W-1:0] sh_mag;
    logic                  sh_guard, sh_sticky, sh_inc;

    // ---------------- S1: classify ----------------
    assign s1_exp_d = $signed({1'b0, data_i[14:10]}) - 6'(FP16_BIAS);

    // NOTE: valid bits and outputs are reset; the datapath registers are not,
    // since every consumer qualifies them with a valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s3_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s1_valid_q  <= input_valid;
            s2_valid_q  <= s1_valid_q;
            s3_valid_q  <= s2_valid_q;
            out_valid_q <= s3_valid_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the previous stage's value from before the edge.
    always_ff @(posedge clk) begin
        s1_sign_q <= data_i[15];
        s1_sig_q  <= {data_i[14:10] != '0, data_i[9:0]};
        s1_cls_q  <= fp16_classify(data_i[14:10], data_i[9:0]);
        s1_exp_q  <= s1_exp_d;
    end

    // ---------------- S2: align ----------------
    assign lsh = 3'(s1_exp_q - 6'sd10);
    assign rsh = 5'(6'sd10 - s1_exp_q);

    fp16_rne_shifter u_shifter (
        .sig_i    (s1_sig_q),
        .shamt_i  (rsh),
        .mag_o    (sh_mag),
        .guard_o  (sh_guard),
        .sticky_o (sh_sticky),
        .inc_o    (sh_inc)
    );

`ifdef FP16TOINT32_FLAGS_EN
    logic s2_guard_q, s2_sticky_q, s2_guard_d, s2_sticky_d;
`else
    logic unused_round_bits;
    assign unused_round_bits = sh_guard | sh_sticky;
`endif

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        s2_mag_d = '0;
        s2_inc_d = 1'b0;
`ifdef FP16TOINT32_FLAGS_EN
        s2_guard_d  = 1'b0;
        s2_sticky_d = 1'b0;
`endif
        unique case (s1_cls_q)
            NORM: begin
                if (s1_exp_q >= 6'sd10) begin
                    s2_mag_d = 17'(s1_sig_q) << lsh;
                end else begin
                    s2_mag_d = 17'(sh_mag);
                    s2_inc_d = sh_inc;
`ifdef FP16TOINT32_FLAGS_EN
                    s2_guard_d  = sh_guard;
                    s2_sticky_d = sh_sticky;
`endif
                end
            end
`ifdef FP16TOINT32_FLAGS_EN
            ZERO_SUB: s2_sticky_d = |s1_sig_q[FP16_MAN_W-1:0];
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        s2_sign_q <= s1_sign_q;
        s2_cls_q  <= s1_cls_q;
        s2_mag_q  <= s2_mag_d;
        s2_inc_q  <= s2_inc_d;
`ifdef FP16TOINT32_FLAGS_EN
        s2_guard_q  <= s2_guard_d;
        s2_sticky_q <= s2_sticky_d;
`endif
    end

    // ---------------- S3: finalize ----------------
    assign mag_rounded = 32'(s2_mag_q) + 32'(s2_inc_q);

    always_comb begin
        s3_data_d = '0;
        unique case (s2_cls_q)
            NORM:     s3_data_d = s2_sign_q ? -mag_rounded : mag_rounded;
            INF:      s3_data_d = s2_sign_q ? INT32_NEG_SAT : INT32_POS_SAT;
            NAN:      s3_data_d = INT32_POS_SAT;
            default:  s3_data_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        s3_data_q <= s3_data_d;
    end

    // ---------------- output register ----------------
    always_ff @(posedge clk) begin
        if (rst)
            data_q <= '0;
        else if (s3_valid_q)
            data_q <= s3_data_q;
    end

`ifdef FP16TOINT32_FLAGS_EN
    logic [1:0] s3_flags_q, flags_q;

    always_ff @(posedge clk) begin
        s3_flags_q <= {(s2_cls_q == INF) || (s2_cls_q == NAN), s2_guard_q | s2_sticky_q};
    end

    always_ff @(posedge clk) begin
        if (rst)
            flags_q <= '0;
        else if (s3_valid_q)
            flags_q <= s3_flags_q;
    end

    assign flags_o = flags_q;
`endif

    assign data_o        = data_q;
    assign output_update = out_valid_q;

endmodule

// File: tb/tb_fp16_to_int32.sv
// Directed-vector bench for fp16_to_int32: checks values, exact latency,
// gap propagation, output hold and mid-flight reset.
module tb_fp16_to_int32;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_i;
    logic        input_valid;
    logic        output_update;
    logic [31:0] data_o;
`ifdef FP16TOINT32_FLAGS_EN
    logic [1:0]  flags_o;
`endif

    fp16_to_int32 dut (
        .clk           (clk),
        .rst           (rst),
        .data_i        (data_i),
        .input_valid   (input_valid),
        .output_update (output_update),
`ifdef FP16TOINT32_FLAGS_EN
        .flags_o       (flags_o),
`endif
        .data_o        (data_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic [31:0] e;
        logic [1:0]  f;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  flags;
        int unsigned cyc;
    } exp_t;

    vec_t        vecs [16];
    exp_t        exp_q [$];
    logic [31:0] exp_last  = '0;
    logic [1:0]  exp_flast = '0;
    int unsigned cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Scoreboard: every update must match the next expected result at its exact cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (output_update) begin
                if (exp_q.size() == 0) begin
                    check("spurious_update", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("data", data_o, e.data);
                    check("latency", 32'(cyc), 32'(e.cyc));
`ifdef FP16TOINT32_FLAGS_EN
                    check("flags", 32'(flags_o), 32'(e.flags));
`endif
                    exp_last  = e.data;
                    exp_flast = e.flags;
                end
            end else begin
                check("hold", data_o, exp_last);
`ifdef FP16TOINT32_FLAGS_EN
                check("flags_hold", 32'(flags_o), 32'(exp_flast));
`endif
            end
        end
    end

    task automatic send(input vec_t v);
        exp_t e;
        @(posedge clk);
        #1;
        data_i      = v.d;
        input_valid = 1'b1;
        e.data  = v.e;
        e.flags = v.f;
        e.cyc   = cyc + 4;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            input_valid = 1'b0;
            data_i      = '0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        check("drain_pending", 32'(exp_q.size()), 32'd0);
        idle(1);
    endtask

    initial begin
        vec_t one;
        vecs[0]  = '{16'h3800, 32'h0000_0000, 2'b01};
        vecs[1]  = '{16'h3E00, 32'h0000_0002, 2'b01};
        vecs[2]  = '{16'h4100, 32'h0000_0002, 2'b01};
        vecs[3]  = '{16'h3A00, 32'h0000_0001, 2'b01};
        vecs[4]  = '{16'hC500, 32'hFFFF_FFFB, 2'b00};
        vecs[5]  = '{16'h7BFF, 32'h0000_FFE0, 2'b00};
        vecs[6]  = '{16'h8000, 32'h0000_0000, 2'b00};
        vecs[7]  = '{16'h0001, 32'h0000_0000, 2'b01};
        vecs[8]  = '{16'h7C00, 32'h7FFF_FFFF, 2'b10};
        vecs[9]  = '{16'hFC00, 32'h8000_0000, 2'b10};
        vecs[10] = '{16'h7E00, 32'h7FFF_FFFF, 2'b10};
        vecs[11] = '{16'hFE00, 32'h7FFF_FFFF, 2'b10};
        vecs[12] = '{16'h4900, 32'h0000_000A, 2'b00};
        vecs[13] = '{16'hBE00, 32'hFFFF_FFFE, 2'b01};
        vecs[14] = '{16'h6400, 32'h0000_0400, 2'b00};
        vecs[15] = '{16'h0400, 32'h0000_0000, 2'b01};
        one      = '{16'h3C00, 32'h0000_0001, 2'b00};

        rst         = 1'b1;
        input_valid = 1'b0;
        data_i      = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_data", data_o, 32'd0);
        check("reset_update", 32'(output_update), 32'd0);

        // single 1.0 pulse
        send(one);
        idle(1);
        drain();

        // six back-to-back, two idle cycles, two more
        for (int i = 0; i < 6; i++) send(vecs[i]);
        idle(2);
        for (int i = 6; i < 8; i++) send(vecs[i]);
        idle(1);
        drain();

        // remaining vectors streamed
        for (int i = 8; i < 16; i++) send(vecs[i]);
        idle(1);
        drain();

        // reset one cycle after two operands, with a coincident input_valid
        send(vecs[4]);
        send(vecs[5]);
        @(posedge clk);
        #1;
        rst         = 1'b1;
        input_valid = 1'b1;
        data_i      = 16'h3C00;
        exp_q.delete();
        exp_last  = '0;
        exp_flast = '0;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        input_valid = 1'b0;
        data_i      = '0;
        @(negedge clk);
        check("flush_data", data_o, 32'd0);
        check("flush_update", 32'(output_update), 32'd0);
        idle(5);

        send(vecs[2]);
        idle(1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
